ibex_hpm_counter_bank: RTL

Parametrised bank of hardware performance monitor counters: the next generation of the fixed mhpmcounter logic in ibex_cs_registers.
- Adds per-counter event selection from a generic event vector, per-counter inhibit, debug-mode freeze, sticky overflow flags and an overflow interrupt.
- Sits beside the CSR file; the CSR decoder forwards mhpmcounter/mhpmcounterh/mhpmevent accesses as (index, field) requests.

---
 rtl/ibex_hpm_pkg.sv | 31 +++
 rtl/ibex_hpm_counter.sv | 84 ++++++++
 rtl/ibex_hpm_counter_bank.sv | 95 +++++++++
 3 files changed

// File: rtl/ibex_hpm_pkg.sv
// Shared types and constants for the hardware performance monitor counter bank.
package ibex_hpm_pkg;

    typedef enum logic [1:0] {
        HPM_CNT_LO = 2'd0,
        HPM_CNT_HI = 2'd1,
        HPM_CFG    = 2'd2,
        HPM_RSVD   = 2'd3
    } hpm_field_e;

    localparam int unsigned HPM_CFG_OF_BIT  = 31;
    localparam int unsigned HPM_CFG_OIE_BIT = 30;
    localparam int unsigned HPM_SEL_W       = 8;

    typedef struct packed {
        logic                 of;
        logic                 oie;
        logic [HPM_SEL_W-1:0] sel;
    } hpm_cfg_t;

    // Architectural view of a cfg register; unlisted bits read as zero.
    function automatic logic [31:0] hpm_cfg_pack(hpm_cfg_t c);
        logic [31:0] word;
        word                  = '0;
        word[HPM_CFG_OF_BIT]  = c.of;
        word[HPM_CFG_OIE_BIT] = c.oie;
        word[HPM_SEL_W-1:0]   = c.sel;
        return word;
    endfunction

endpackage

// File: rtl/ibex_hpm_counter.sv
// One performance counter with its event select, overflow enable and sticky
// overflow flag; a CSR write to either count half takes priority over counting.
module ibex_hpm_counter
    import ibex_hpm_pkg::*;
#(
    parameter int unsigned CounterWidth = 40,
    parameter int unsigned NumEvents    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumEvents-1:0] event_i,
    input  logic                 inhibit_i,
    input  logic                 freeze_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic                 wr_cfg_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          cnt_lo_o,
    output logic [31:0]          cnt_hi_o,
    output hpm_cfg_t             cfg_o
);

    logic [CounterWidth-1:0] count_q, count_d, hi_load;
    hpm_cfg_t                cfg_q, cfg_d;
    logic [255:0]            ev_ext;
    logic                    inc, wrap;
    logic [HPM_SEL_W-1:0]    wsel;

    // SEL of zero maps to the constant-zero bit 0, so no separate enable test is needed.
    always_comb begin
        ev_ext              = '0;
        ev_ext[NumEvents:1] = event_i;
    end

    assign inc  = ev_ext[cfg_q.sel] && !inhibit_i && !freeze_i && !wr_lo_i && !wr_hi_i;
    assign wrap = inc && (&count_q);
    assign wsel = (wdata_i[HPM_SEL_W-1:0] > HPM_SEL_W'(NumEvents)) ? '0 : wdata_i[HPM_SEL_W-1:0];

    if (CounterWidth > 32) begin : g_hi
        assign hi_load  = {wdata_i[CounterWidth-33:0], count_q[31:0]};
        assign cnt_hi_o = 32'(count_q[CounterWidth-1:32]);
    end else begin : g_no_hi
        assign hi_load  = count_q;
        assign cnt_hi_o = '0;
    end

    assign cnt_lo_o = count_q[31:0];
    assign cfg_o    = cfg_q;

    always_comb begin
        count_d = count_q;
        if (wr_lo_i) begin
            count_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            count_d = hi_load;
        end else if (inc) begin
            count_d = count_q + CounterWidth'(1);
        end
    end

    // A hardware overflow in the same cycle as a software clear leaves OF set.
    always_comb begin
        cfg_d = cfg_q;
        if (wr_cfg_i) begin
            cfg_d.sel = wsel;
            cfg_d.oie = wdata_i[HPM_CFG_OIE_BIT];
            cfg_d.of  = wdata_i[HPM_CFG_OF_BIT];
        end
        if (wrap) begin
            cfg_d.of = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            cfg_q   <= '0;
        end else begin
            count_q <= count_d;
            cfg_q   <= cfg_d;
        end
    end

endmodule

// File: rtl/ibex_hpm_counter_bank.sv
// Bank of HPM counters: CSR access decode, read mux and registered overflow interrupt.
module ibex_hpm_counter_bank
    import ibex_hpm_pkg::*;
#(
    parameter int unsigned NumCounters  = 8,
    parameter int unsigned CounterWidth = 40,
    parameter int unsigned NumEvents    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumEvents-1:0]   event_i,
    input  logic [NumCounters-1:0] inhibit_i,
    input  logic                   debug_mode_i,
    input  logic                   stopcount_i,
    input  logic                   csr_en_i,
    input  logic                   csr_we_i,
    input  logic [4:0]             csr_sel_i,
    input  logic [1:0]             csr_field_i,
    input  logic [31:0]            csr_wdata_i,
    output logic [31:0]            csr_rdata_o,
    output logic                   csr_error_o,
    output logic [NumCounters-1:0] of_o,
    output logic                   irq_overflow_o
);

    logic [31:0]            lo_rd  [NumCounters];
    logic [31:0]            hi_rd  [NumCounters];
    hpm_cfg_t               cfg    [NumCounters];
    logic [NumCounters-1:0] irq_pend;
    logic                   acc_ok, wr_ok, freeze;
    logic                   irq_q, irq_d;

    // Each CSR access is a single-cycle request: it is valid when csr_en_i is high,
    // there is no ready/backpressure, reads complete combinationally and writes on that edge.
    assign csr_error_o = csr_en_i &&
                         (({1'b0, csr_sel_i} >= 6'(NumCounters)) || (csr_field_i == HPM_RSVD));
    assign acc_ok      = csr_en_i && !csr_error_o;
    assign wr_ok       = acc_ok && csr_we_i;
    assign freeze      = debug_mode_i && stopcount_i;

    for (genvar i = 0; i < NumCounters; i++) begin : g_cnt
        logic hit;
        assign hit = wr_ok && (csr_sel_i == 5'(i));

        ibex_hpm_counter #(
            .CounterWidth (CounterWidth),
            .NumEvents    (NumEvents)
        ) u_counter (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .event_i   (event_i),
            .inhibit_i (inhibit_i[i]),
            .freeze_i  (freeze),
            .wr_lo_i   (hit && (csr_field_i == HPM_CNT_LO)),
            .wr_hi_i   (hit && (csr_field_i == HPM_CNT_HI)),
            .wr_cfg_i  (hit && (csr_field_i == HPM_CFG)),
            .wdata_i   (csr_wdata_i),
            .cnt_lo_o  (lo_rd[i]),
            .cnt_hi_o  (hi_rd[i]),
            .cfg_o     (cfg[i])
        );

        assign of_o[i]     = cfg[i].of;
        assign irq_pend[i] = cfg[i].of && cfg[i].oie;
    end

    always_comb begin
        csr_rdata_o = '0;
        if (acc_ok) begin
            for (int i = 0; i < NumCounters; i++) begin
                if (csr_sel_i == 5'(i)) begin
                    case (hpm_field_e'(csr_field_i))
                        HPM_CNT_LO: csr_rdata_o = lo_rd[i];
                        HPM_CNT_HI: csr_rdata_o = hi_rd[i];
                        HPM_CFG:    csr_rdata_o = hpm_cfg_pack(cfg[i]);
                        default:    csr_rdata_o = '0;
                    endcase
                end
            end
        end
    end

    assign irq_d = |irq_pend;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_overflow_o = irq_q;

endmodule
